// File: rtl/pe_dot_stream.sv
// Streaming LANES-wide integer dot-product engine: multiply, adder tree, accumulate per vector.
// Optional saturating accumulator when PE_DOT_SAT_EN is defined; otherwise results wrap.
module pe_dot_stream #(
   parameter int unsigned LANES = 8,
   parameter int unsigned DW    = 32,
   parameter int unsigned ACC_W = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [LANES*DW-1:0] in_x,
   input  logic [LANES*DW-1:0] in_y,
   input  logic [LANES-1:0]    in_mask,
   input  logic                in_last,
   input  logic                use_signed,
   input  logic                op_sub,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ACC_W-1:0]    out_data,
   output logic [CNT_W-1:0]    out_count,
   output logic                out_ovf,
   output logic                busy
);

   localparam int unsigned LW = $clog2(LANES);
   localparam int unsigned PW = 2 * DW;
   localparam int unsigned SW = PW + LW;
   localparam int unsigned AW = SW + 1;

   typedef enum logic [1:0] {StIdle, StAccum, StDrain, StOut} state_e;

   state_e state_q, state_d;

   logic accept;
   logic first_beat;
   logic eff_signed;
   logic drain_done;

   logic mode_signed_q;
   logic mode_sub_q;

   logic [LANES-1:0][PW-1:0] prod_d;
   logic [LANES-1:0][PW-1:0] prod_q;
   logic                     s1_valid_q;
   logic                     s1_first_q;

   logic [LANES-1:0][SW-1:0] lvl;
   logic [SW-1:0]            sum_d;
   logic [SW-1:0]            sum_q;
   logic                     s2_valid_q;
   logic                     s2_first_q;

   logic [AW-1:0]    acc_ext;
   logic [AW-1:0]    sum_ext;
   logic [AW-1:0]    base;
   logic [AW-1:0]    step;
   logic [ACC_W-1:0] acc_d;
   logic [ACC_W-1:0] acc_q;
   logic             clamp;
   logic             ovf_q;
   logic [CNT_W-1:0] cnt_q;

   logic [ACC_W-1:0] out_data_q;
   logic [CNT_W-1:0] out_count_q;
   logic             out_ovf_q;

   function automatic logic [PW-1:0] ext_op(input logic [DW-1:0] v, input logic sgn);
      return {{DW{sgn & v[DW-1]}}, v};
   endfunction

   assign first_beat = (state_q == StIdle);
   assign in_ready   = reset & ((state_q == StIdle) | (state_q == StAccum));
   assign accept     = in_valid & in_ready;
   // The first beat carries the mode live; later beats use the value captured with it.
   assign eff_signed = first_beat ? use_signed : mode_signed_q;
   assign drain_done = (state_q == StDrain) & ~s1_valid_q & ~s2_valid_q;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = in_last ? StDrain : StAccum;
            end
         end
         StAccum: begin
            if (accept && in_last) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (drain_done) begin
               state_d = StOut;
            end
         end
         StOut: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         mode_signed_q <= 1'b0;
         mode_sub_q    <= 1'b0;
      end else if (accept && first_beat) begin
         mode_signed_q <= use_signed;
         mode_sub_q    <= op_sub;
      end
   end

   // ---------------------------------------------------------------- S1: lane products
   always_comb begin
      prod_d = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         if (in_mask[i]) begin
            prod_d[i] = ext_op(in_x[i*DW +: DW], eff_signed) * ext_op(in_y[i*DW +: DW], eff_signed);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         s1_valid_q <= 1'b0;
         s1_first_q <= 1'b0;
         prod_q     <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_first_q <= first_beat;
            prod_q     <= prod_d;
         end
      end
   end

   // ---------------------------------------------------------------- S2: adder tree
   // Pairwise reduction in place: each level writes indices below the ones it reads.
   always_comb begin
      for (int i = 0; i < int'(LANES); i++) begin
         lvl[i] = {{LW{mode_signed_q & prod_q[i][PW-1]}}, prod_q[i]};
      end
      for (int w = int'(LANES / 2); w >= 1; w = w / 2) begin
         for (int i = 0; i < w; i++) begin
            lvl[i] = lvl[2*i] + lvl[2*i+1];
         end
      end
      sum_d = lvl[0];
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         s2_valid_q <= 1'b0;
         s2_first_q <= 1'b0;
         sum_q      <= '0;
      end else begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_first_q <= s1_first_q;
            sum_q      <= sum_d;
         end
      end
   end

   // ---------------------------------------------------------------- S3: accumulate
   // One guard bit above SW keeps the step exact before reduction to ACC_W.
   always_comb begin
      acc_ext = {{(AW-ACC_W){mode_signed_q & acc_q[ACC_W-1]}}, acc_q};
      sum_ext = {mode_signed_q & sum_q[SW-1], sum_q};
      base    = s2_first_q ? '0 : acc_ext;
      step    = mode_sub_q ? (base - sum_ext) : (base + sum_ext);
   end

`ifdef PE_DOT_SAT_EN
   localparam logic [AW-1:0] SMAX = {{(AW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
   localparam logic [AW-1:0] SMIN = {{(AW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
   localparam logic [AW-1:0] UMAX = {{(AW-ACC_W){1'b0}}, {ACC_W{1'b1}}};

   always_comb begin
      acc_d = step[ACC_W-1:0];
      clamp = 1'b0;
      if (mode_signed_q) begin
         if ($signed(step) > $signed(SMAX)) begin
            acc_d = {1'b0, {(ACC_W-1){1'b1}}};
            clamp = 1'b1;
         end else if ($signed(step) < $signed(SMIN)) begin
            acc_d = {1'b1, {(ACC_W-1){1'b0}}};
            clamp = 1'b1;
         end
      end else begin
         if (step[AW-1]) begin
            acc_d = '0;
            clamp = 1'b1;
         end else if (step > UMAX) begin
            acc_d = '1;
            clamp = 1'b1;
         end
      end
   end
`else
   logic unused_step_hi;

   assign acc_d          = step[ACC_W-1:0];
   assign clamp          = 1'b0;
   assign unused_step_hi = ^step[AW-1:ACC_W];
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else if (s2_valid_q) begin
         acc_q <= acc_d;
         ovf_q <= clamp | (ovf_q & ~s2_first_q);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= first_beat ? CNT_W'(1) : cnt_q + CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------- result registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         out_data_q  <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
      end else if (drain_done) begin
         out_data_q  <= acc_q;
         out_count_q <= cnt_q;
         out_ovf_q   <= ovf_q;
      end
   end

   assign out_valid = (state_q == StOut);
   assign out_data  = out_data_q;
   assign out_count = out_count_q;
   assign out_ovf   = out_ovf_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_pe_dot_stream.sv
// Directed bench for pe_dot_stream at default parameters; expected values are hand-computed.
module tb_pe_dot_stream;

   localparam int unsigned LANES = 8;
   localparam int unsigned DW    = 32;
   localparam int unsigned ACC_W = 32;
   localparam int unsigned CNT_W = 16;

`ifdef PE_DOT_SAT_EN
   localparam logic [31:0] EXP_UBIG     = 32'hFFFF_FFFF;
   localparam logic        EXP_UBIG_OVF = 1'b1;
   localparam logic [31:0] EXP_SBIG     = 32'h7FFF_FFFF;
   localparam logic        EXP_SBIG_OVF = 1'b1;
   localparam logic [31:0] EXP_USUB     = 32'h0000_0000;
   localparam logic        EXP_USUB_OVF = 1'b1;
`else
   localparam logic [31:0] EXP_UBIG     = 32'h0000_0000;
   localparam logic        EXP_UBIG_OVF = 1'b0;
   localparam logic [31:0] EXP_SBIG     = 32'h0000_0000;
   localparam logic        EXP_SBIG_OVF = 1'b0;
   localparam logic [31:0] EXP_USUB     = 32'hFFFF_FFFF;
   localparam logic        EXP_USUB_OVF = 1'b0;
`endif

   logic                clock;
   logic                reset;
   logic                in_valid;
   logic                in_ready;
   logic [LANES*DW-1:0] in_x;
   logic [LANES*DW-1:0] in_y;
   logic [LANES-1:0]    in_mask;
   logic                in_last;
   logic                use_signed;
   logic                op_sub;
   logic                out_valid;
   logic                out_ready;
   logic [ACC_W-1:0]    out_data;
   logic [CNT_W-1:0]    out_count;
   logic                out_ovf;
   logic                busy;

   int n_vec = 0;
   int n_err = 0;

   pe_dot_stream #(
      .LANES (LANES),
      .DW    (DW),
      .ACC_W (ACC_W),
      .CNT_W (CNT_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .in_y       (in_y),
      .in_mask    (in_mask),
      .in_last    (in_last),
      .use_signed (use_signed),
      .op_sub     (op_sub),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_count  (out_count),
      .out_ovf    (out_ovf),
      .busy       (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_ops(input logic [DW-1:0] xe, input logic [DW-1:0] ye,
                          input logic [DW-1:0] xo, input logic [DW-1:0] yo);
      for (int i = 0; i < int'(LANES); i++) begin
         in_x[i*DW +: DW] = (i % 2 == 0) ? xe : xo;
         in_y[i*DW +: DW] = (i % 2 == 0) ? ye : yo;
      end
   endtask

   // Called #1 after the edge that accepted the last beat; result must appear 3 edges later.
   task automatic wait_result();
      int lat;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      check("latency", 64'(lat), 64'd3);
   endtask

   task automatic run_vec(input int n, input logic [7:0] m0, input logic [7:0] m1,
                          input logic s0, input logic b0, input logic s1, input logic b1);
      for (int b = 0; b < n; b++) begin
         in_valid   = 1'b1;
         in_last    = (b == n - 1);
         in_mask    = (b == 0) ? m0 : m1;
         use_signed = (b == 0) ? s0 : s1;
         op_sub     = (b == 0) ? b0 : b1;
         check("in_ready_beat", 64'(in_ready), 64'd1);
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      wait_result();
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("consume_valid", 64'(out_valid), 64'd0);
      check("consume_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      reset      = 1'b0;
      in_valid   = 1'b0;
      in_last    = 1'b0;
      in_mask    = '0;
      use_signed = 1'b0;
      op_sub     = 1'b0;
      out_ready  = 1'b0;
      set_ops(32'd23, 32'd11, -32'sd55, -32'sd11);
      tick();
      tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_count", 64'(out_count), 64'd0);
      check("rst_out_ovf", 64'(out_ovf), 64'd0);
      reset = 1'b1;
      #1;
      check("idle_in_ready", 64'(in_ready), 64'd1);

      // 1) signed, 2 beats, add
      run_vec(2, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
      check("t1_data", 64'(out_data), 64'h0000_1AD0);
      check("t1_count", 64'(out_count), 64'd2);
      check("t1_ovf", 64'(out_ovf), 64'd0);
      check("t1_in_ready", 64'(in_ready), 64'd0);
      check("t1_busy", 64'(busy), 64'd1);
      consume();

      // 2) same with subtract
      run_vec(2, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);
      check("t2_data", 64'(out_data), 64'hFFFF_E530);
      check("t2_ovf", 64'(out_ovf), 64'd0);
      consume();

      // mode bits on a later beat are ignored
      run_vec(2, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
      check("hold_mode_data", 64'(out_data), 64'd6864);
      consume();

      // fully masked beat contributes 0 but still counts
      run_vec(2, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
      check("masked_data", 64'(out_data), 64'd3432);
      check("masked_count", 64'(out_count), 64'd2);
      consume();

      // 3) single beat, half lanes
      run_vec(1, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      check("t3_data", 64'(out_data), 64'd1716);
      check("t3_count", 64'(out_count), 64'd1);

      // 4) backpressure with the next vector already offered
      in_valid   = 1'b1;
      in_last    = 1'b1;
      in_mask    = 8'hFF;
      use_signed = 1'b1;
      op_sub     = 1'b0;
      for (int c = 0; c < 5; c++) begin
         check("bp_valid", 64'(out_valid), 64'd1);
         check("bp_data", 64'(out_data), 64'd1716);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_rel_valid", 64'(out_valid), 64'd0);
      check("bp_rel_busy", 64'(busy), 64'd0);
      check("bp_rel_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("bp_next_busy", 64'(busy), 64'd1);
      wait_result();
      check("bp_next_data", 64'(out_data), 64'd3432);
      check("bp_next_count", 64'(out_count), 64'd1);
      consume();

      // 5) unsigned overflow
      set_ops(32'd65536, 32'd32768, 32'd65536, 32'd32768);
      run_vec(1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t5_data", 64'(out_data), 64'(EXP_UBIG));
      check("t5_ovf", 64'(out_ovf), 64'(EXP_UBIG_OVF));
      consume();

      // signed overflow: 8 * 2^62
      set_ops(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
      run_vec(1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      check("sbig_data", 64'(out_data), 64'(EXP_SBIG));
      check("sbig_ovf", 64'(out_ovf), 64'(EXP_SBIG_OVF));
      consume();

      // unsigned subtract below zero
      set_ops(32'd1, 32'd1, 32'd1, 32'd1);
      run_vec(1, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
      check("usub_data", 64'(out_data), 64'(EXP_USUB));
      check("usub_ovf", 64'(out_ovf), 64'(EXP_USUB_OVF));
      consume();

      // 6) reset mid-vector
      set_ops(32'd23, 32'd11, -32'sd55, -32'sd11);
      in_valid   = 1'b1;
      in_last    = 1'b0;
      in_mask    = 8'hFF;
      use_signed = 1'b1;
      op_sub     = 1'b0;
      tick();
      in_valid = 1'b0;
      reset    = 1'b0;
      #1;
      check("t6_in_ready_rst", 64'(in_ready), 64'd0);
      tick();
      check("t6_valid", 64'(out_valid), 64'd0);
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_data", 64'(out_data), 64'd0);
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
      end
      check("t6_quiet", 64'(out_valid), 64'd0);
      run_vec(2, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
      check("t6_rerun_data", 64'(out_data), 64'd6864);
      check("t6_rerun_count", 64'(out_count), 64'd2);
      consume();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
